// File: rtl/axi4_lite_pkg.sv
// Shared types and the byte-strobe merge helper for the AXI4-Lite write manager.
package axi4_lite_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WRITE = 2'b01,
    RESP  = 2'b10
  } write_state_t;

  // The merge works on a fixed maximum width; callers zero-extend and slice.
  localparam int MAX_DATA_SIZE = 256;
  localparam int MAX_STRB_SIZE = MAX_DATA_SIZE / 8;

  function automatic logic [MAX_DATA_SIZE-1:0] strobe_merge(
    input logic [MAX_DATA_SIZE-1:0] old_word,
    input logic [MAX_DATA_SIZE-1:0] new_word,
    input logic [MAX_STRB_SIZE-1:0] strb
  );
    logic [MAX_DATA_SIZE-1:0] merged;
    merged = old_word;
    for (int b = 0; b < MAX_STRB_SIZE; b++) begin
      if (strb[b]) begin
        merged[b*8 +: 8] = new_word[b*8 +: 8];
      end else begin
        merged[b*8 +: 8] = old_word[b*8 +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/axi4_lite_channel_slot.sv
// One-entry channel hold register with a valid flag, registered ready and clear.
module axi4_lite_channel_slot #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_clk_ni,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             enable_i,
  input  logic             clear_i,
  output logic             ready_o,
  output logic             full_o,
  output logic             full_next_o,
  output logic [WIDTH-1:0] data_o
);

  logic             full_r;
  logic             ready_r;
  logic [WIDTH-1:0] data_r;
  logic             capture_s;

  // Next fill state; ready only opens when the slot is empty, so clear and capture never coincide
  always_comb begin
    capture_s = valid_i && ready_r;
    if (clear_i) begin
      full_next_o = 1'b0;
    end else if (capture_s) begin
      full_next_o = 1'b1;
    end else begin
      full_next_o = full_r;
    end
  end

  // Slot state, held payload and registered ready
  always_ff @(posedge clk_i or negedge rst_clk_ni) begin
    if (!rst_clk_ni) begin
      full_r  <= 1'b0;
      ready_r <= 1'b0;
      data_r  <= '0;
    end else begin
      full_r  <= full_next_o;
      ready_r <= enable_i && !full_next_o;
      if (capture_s) begin
        data_r <= data_i;
      end
    end
  end

  assign ready_o = ready_r;
  assign full_o  = full_r;
  assign data_o  = data_r;

endmodule

// File: rtl/axi4_lite_write_manager.sv
// AXI4-Lite write subordinate committing to a register bank.
// Optional AXI4_LITE_WRITE_STROBE_EN enables per-byte write strobes.
module axi4_lite_write_manager #(
  parameter int ADDRESS_SIZE = 32,
  parameter int DATA_SIZE    = 32,
  parameter int NUM_REGS     = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_clk_ni,
  input  logic [ADDRESS_SIZE-1:0]       write_address_i,
  input  logic                          write_address_valid_i,
  output logic                          write_address_ready_o,
  input  logic [DATA_SIZE-1:0]          write_data_i,
  input  logic [DATA_SIZE/8-1:0]        write_strobe_i,
  input  logic                          write_data_valid_i,
  output logic                          write_data_ready_o,
  output logic [1:0]                    write_response_o,
  output logic                          write_response_valid_o,
  input  logic                          write_response_ready_i,
  output logic [NUM_REGS*DATA_SIZE-1:0] registers_o,
  output logic [NUM_REGS-1:0]           register_write_pulse_o
);
  import axi4_lite_pkg::*;

  localparam int STRB_SIZE = DATA_SIZE / 8;
  localparam int IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int W_WIDTH   = DATA_SIZE + STRB_SIZE;

  write_state_t             state_r;
  write_state_t             state_next_s;
  logic                     clear_s;
  logic                     aw_full_s, aw_full_next_s;
  logic                     w_full_s, w_full_next_s;
  logic [ADDRESS_SIZE-1:0]  aw_addr_s;
  logic [W_WIDTH-1:0]       w_slot_s;
  logic [DATA_SIZE-1:0]     w_data_s;
  logic [STRB_SIZE-1:0]     w_strb_s;
  logic [IDX_W-1:0]         index_s;
  logic [ADDRESS_SIZE-1:0]  upper_s;
  resp_t                    resp_s;
  logic [DATA_SIZE-1:0]     commit_word_s;
  logic [DATA_SIZE-1:0]     bank_r [NUM_REGS];
  logic [NUM_REGS-1:0]      pulse_r;
  logic                     bvalid_r;
  resp_t                    bresp_r;
  logic                     unused_s;

  axi4_lite_channel_slot #(.WIDTH(ADDRESS_SIZE)) u_aw_slot (
    .clk_i       (clk_i),
    .rst_clk_ni  (rst_clk_ni),
    .valid_i     (write_address_valid_i),
    .data_i      (write_address_i),
    .enable_i    (state_next_s == IDLE),
    .clear_i     (clear_s),
    .ready_o     (write_address_ready_o),
    .full_o      (aw_full_s),
    .full_next_o (aw_full_next_s),
    .data_o      (aw_addr_s)
  );

  axi4_lite_channel_slot #(.WIDTH(W_WIDTH)) u_w_slot (
    .clk_i       (clk_i),
    .rst_clk_ni  (rst_clk_ni),
    .valid_i     (write_data_valid_i),
    .data_i      ({write_strobe_i, write_data_i}),
    .enable_i    (state_next_s == IDLE),
    .clear_i     (clear_s),
    .ready_o     (write_data_ready_o),
    .full_o      (w_full_s),
    .full_next_o (w_full_next_s),
    .data_o      (w_slot_s)
  );

  assign w_data_s = w_slot_s[DATA_SIZE-1:0];
  assign w_strb_s = w_slot_s[W_WIDTH-1:DATA_SIZE];

  // State register
  always_ff @(posedge clk_i or negedge rst_clk_ni) begin
    if (!rst_clk_ni) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next state; the full_next terms let a same-edge AW+W capture start WRITE directly
  always_comb begin
    state_next_s = state_r;
    clear_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (aw_full_next_s && w_full_next_s) begin
          state_next_s = WRITE;
        end else begin
          state_next_s = IDLE;
        end
      end
      WRITE: begin
        state_next_s = RESP;
      end
      RESP: begin
        if (write_response_ready_i) begin
          state_next_s = IDLE;
          clear_s      = 1'b1;
        end else begin
          state_next_s = RESP;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Address decode and the word to commit
`ifdef AXI4_LITE_WRITE_STROBE_EN
  logic [MAX_DATA_SIZE-1:0] old_ext_s, new_ext_s, merged_s;
  logic [MAX_STRB_SIZE-1:0] strb_ext_s;
`endif
  always_comb begin
    index_s = aw_addr_s[IDX_W+1:2];
    upper_s = aw_addr_s >> (IDX_W + 2);
    if ((upper_s == '0) && (int'(index_s) < NUM_REGS)) begin
      resp_s = RESP_OKAY;
    end else begin
      resp_s = RESP_SLVERR;
    end
`ifdef AXI4_LITE_WRITE_STROBE_EN
    old_ext_s  = '0;
    new_ext_s  = '0;
    strb_ext_s = '0;
    old_ext_s[DATA_SIZE-1:0] = bank_r[index_s];
    new_ext_s[DATA_SIZE-1:0] = w_data_s;
    strb_ext_s[STRB_SIZE-1:0] = w_strb_s;
    merged_s      = strobe_merge(old_ext_s, new_ext_s, strb_ext_s);
    commit_word_s = merged_s[DATA_SIZE-1:0];
    unused_s      = ^{aw_addr_s[1:0], aw_full_s, w_full_s};
`else
    commit_word_s = w_data_s;
    unused_s      = ^{aw_addr_s[1:0], w_strb_s, aw_full_s, w_full_s};
`endif
  end

  // Register bank, commit pulses and B channel
  always_ff @(posedge clk_i or negedge rst_clk_ni) begin
    if (!rst_clk_ni) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        bank_r[k] <= '0;
      end
      pulse_r  <= '0;
      bvalid_r <= 1'b0;
      bresp_r  <= RESP_OKAY;
    end else begin
      pulse_r <= '0;
      case (state_r)
        WRITE: begin
          bvalid_r <= 1'b1;
          bresp_r  <= resp_s;
          if (resp_s == RESP_OKAY) begin
            bank_r[index_s]  <= commit_word_s;
            pulse_r[index_s] <= 1'b1;
          end
        end
        RESP: begin
          if (write_response_ready_i) begin
            bvalid_r <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs
    assign registers_o[k*DATA_SIZE +: DATA_SIZE] = bank_r[k];
  end

  assign register_write_pulse_o = pulse_r;
  assign write_response_valid_o = bvalid_r;
  assign write_response_o       = bresp_r;

endmodule

// File: tb/tb_axi4_lite_write_manager.sv
// Directed, table-driven bench for axi4_lite_write_manager (default 32-bit, 4 registers).
module tb_axi4_lite_write_manager;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  awaddr;
  logic         awvalid;
  logic         awready;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         wvalid;
  logic         wready;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready;
  logic [127:0] regs;
  logic [3:0]   pulse;

  int passed = 0;
  int total  = 0;

  logic [31:0] exp_bank [4];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [3:0]  pulse;
    logic [31:0] val;
  } vec_t;

  vec_t vecs [7];

  axi4_lite_write_manager dut (
    .clk_i                  (clk),
    .rst_clk_ni             (rst_n),
    .write_address_i        (awaddr),
    .write_address_valid_i  (awvalid),
    .write_address_ready_o  (awready),
    .write_data_i           (wdata),
    .write_strobe_i         (wstrb),
    .write_data_valid_i     (wvalid),
    .write_data_ready_o     (wready),
    .write_response_o       (bresp),
    .write_response_valid_o (bvalid),
    .write_response_ready_i (bready),
    .registers_o            (regs),
    .register_write_pulse_o (pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      passed++;
    end
  endtask

  function automatic logic [127:0] bank_packed();
    return {exp_bank[3], exp_bank[2], exp_bank[1], exp_bank[0]};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; awaddr = 32'h0; awvalid = 1'b0; wdata = 32'h0;
    wstrb = 4'h0; wvalid = 1'b0; bready = 1'b0;
    for (int k = 0; k < 4; k++) exp_bank[k] = 32'h0;

    vecs[0] = '{32'h0000_0004, 32'hDEAD_BEEF, 4'hF, 2'b00, 4'b0010, 32'hDEAD_BEEF};
    vecs[1] = '{32'h0000_0008, 32'hFFFF_FFFF, 4'hF, 2'b00, 4'b0100, 32'hFFFF_FFFF};
`ifdef AXI4_LITE_WRITE_STROBE_EN
    vecs[2] = '{32'h0000_000A, 32'h0000_0000, 4'b0101, 2'b00, 4'b0100, 32'hFF00_FF00};
    vecs[4] = '{32'h0000_000C, 32'hCAFE_F00D, 4'b1000, 2'b00, 4'b1000, 32'hCA00_0000};
    vecs[6] = '{32'h0000_0000, 32'h0BAD_F00D, 4'b0000, 2'b00, 4'b0001, 32'h0000_0000};
`else
    vecs[2] = '{32'h0000_000A, 32'h0000_0000, 4'b0101, 2'b00, 4'b0100, 32'h0000_0000};
    vecs[4] = '{32'h0000_000C, 32'hCAFE_F00D, 4'b1000, 2'b00, 4'b1000, 32'hCAFE_F00D};
    vecs[6] = '{32'h0000_0000, 32'h0BAD_F00D, 4'b0000, 2'b00, 4'b0001, 32'h0BAD_F00D};
`endif
    vecs[3] = '{32'h0000_0100, 32'h1111_1111, 4'hF, 2'b10, 4'b0000, 32'h0000_0000};
    vecs[5] = '{32'h8000_0000, 32'h2222_2222, 4'hF, 2'b10, 4'b0000, 32'h0000_0000};

    // Reset state
    tick();
    check("reset_awready", awready, 1'b0);
    check("reset_wready", wready, 1'b0);
    check("reset_bvalid", bvalid, 1'b0);
    check("reset_bresp", bresp, 2'b00);
    check("reset_regs", regs, 128'h0);
    check("reset_pulse", pulse, 4'h0);
    rst_n = 1'b1;
    tick();
    check("release_awready", awready, 1'b1);
    check("release_wready", wready, 1'b1);

    // Table: same-cycle AW+W, BREADY high, 3 cycles per write
    bready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      check($sformatf("v%0d_awready", i), awready, 1'b1);
      check($sformatf("v%0d_wready", i), wready, 1'b1);
      awaddr = vecs[i].addr; wdata = vecs[i].data; wstrb = vecs[i].strb;
      awvalid = 1'b1; wvalid = 1'b1;
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
      check($sformatf("v%0d_ready_drop", i), {awready, wready, bvalid}, 3'b000);
      tick();
      for (int k = 0; k < 4; k++) if (vecs[i].pulse[k]) exp_bank[k] = vecs[i].val;
      check($sformatf("v%0d_bvalid", i), bvalid, 1'b1);
      check($sformatf("v%0d_bresp", i), bresp, vecs[i].resp);
      check($sformatf("v%0d_pulse", i), pulse, vecs[i].pulse);
      check($sformatf("v%0d_regs", i), regs, bank_packed());
      tick();
      check($sformatf("v%0d_b_done", i), {bvalid, pulse}, 5'b0_0000);
    end

    // W three cycles before AW
    wdata = 32'h1234_5678; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    check("wfirst_wready_low", wready, 1'b0);
    check("wfirst_awready_high", awready, 1'b1);
    for (int c = 0; c < 2; c++) begin
      tick();
      check($sformatf("wfirst_wait%0d", c), {awready, wready, bvalid}, 3'b100);
    end
    awaddr = 32'h0; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    check("wfirst_awready_low", awready, 1'b0);
    tick();
    exp_bank[0] = 32'h1234_5678;
    check("wfirst_bvalid", bvalid, 1'b1);
    check("wfirst_bresp", bresp, 2'b00);
    check("wfirst_pulse", pulse, 4'b0001);
    check("wfirst_regs", regs, bank_packed());
    tick();
    check("wfirst_b_done", bvalid, 1'b0);

    // BREADY held low 5 cycles; a second write waits behind the B handshake
    bready = 1'b0;
    awaddr = 32'h4; wdata = 32'h55AA_55AA; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    tick();
    exp_bank[1] = 32'h55AA_55AA;
    check("hold_bvalid_set", bvalid, 1'b1);
    check("hold_pulse", pulse, 4'b0010);
    awaddr = 32'h8; wdata = 32'h7777_7777; awvalid = 1'b1; wvalid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      check($sformatf("hold%0d_b", c), {bvalid, bresp}, 3'b100);
      check($sformatf("hold%0d_ready", c), {awready, wready, pulse}, 6'b00_0000);
    end
    bready = 1'b1;
    tick();
    check("hold_released", {bvalid, awready, wready}, 3'b011);
    check("hold_regs_first", regs, bank_packed());
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    check("second_captured", {awready, wready}, 2'b00);
    tick();
    exp_bank[2] = 32'h7777_7777;
    check("second_b", {bvalid, bresp, pulse}, 7'b1_00_0100);
    check("second_regs", regs, bank_packed());
    tick();
    check("second_b_done", bvalid, 1'b0);

    // Reset while in RESP
    bready = 1'b0;
    awaddr = 32'hC; wdata = 32'h1357_9BDF; awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    tick();
    check("rst_resp_bvalid", bvalid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_async_b", {bvalid, pulse, awready, wready}, 7'b0);
    check("rst_async_regs", regs, 128'h0);
    tick();
    rst_n = 1'b1;
    bready = 1'b1;
    tick();
    check("rst_after_ready", {awready, wready}, 2'b11);
    tick();
    check("rst_no_b", {bvalid, pulse}, 5'b0);
    check("rst_regs_stay", regs, 128'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
